// File: rtl/shot_sequencer.sv
// shot_sequencer: two-player fire controller with launch/flight/cooldown sequencing, hit counting and win/restart handling
module shot_sequencer #(
  parameter logic [7:0]  FIRE_KEY1       = 8'h2C,
  parameter logic [7:0]  FIRE_KEY2       = 8'h28,
  parameter logic [7:0]  RESTART_KEY     = 8'h15,
  parameter int unsigned COOLDOWN_FRAMES = 15,
  parameter int unsigned MAX_FLIGHT      = 120,
  parameter int unsigned WIN_HITS        = 5
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [31:0] keycode,
  input  logic [9:0]  tank1_xmotion,
  input  logic [9:0]  tank1_ymotion,
  input  logic [9:0]  tank2_xmotion,
  input  logic [9:0]  tank2_ymotion,
  input  logic        bullet1_done,
  input  logic        bullet2_done,
  input  logic        shot_hit1,
  input  logic        shot_hit2,
  output logic        fire1,
  output logic        fire2,
  output logic [1:0]  fire_dir1,
  output logic [1:0]  fire_dir2,
  output logic        busy1,
  output logic        busy2,
  output logic [3:0]  hits1,
  output logic [3:0]  hits2,
  output logic        game_over_display,
  output logic        game_over_display2
);
  typedef enum logic [1:0] {IDLE, LAUNCH, FLIGHT, COOLDOWN} state_t;

  function automatic logic has_key(input logic [31:0] kc, input logic [7:0] k);
    return kc[7:0] == k || kc[15:8] == k || kc[23:16] == k || kc[31:24] == k;
  endfunction

  state_t     st_q[2], st_d[2];
  logic [7:0] cnt_q[2], cnt_d[2];
  logic [1:0] head_q[2], head_d[2], dir_q[2], dir_d[2];
  logic [3:0] hits_q[2], hits_d[2];
  logic [9:0] xm[2], ym[2];
  logic [2:0] key_now, key_q, key_d, kedge;
  logic [1:0] fire_q, fire_d, busy_q, busy_d, go_q, go_d, done, hit;
  logic       restart, frz;

  assign key_now = {has_key(keycode, RESTART_KEY), has_key(keycode, FIRE_KEY2), has_key(keycode, FIRE_KEY1)};
  assign xm[0] = tank1_xmotion;
  assign ym[0] = tank1_ymotion;
  assign xm[1] = tank2_xmotion;
  assign ym[1] = tank2_ymotion;
  assign done = {bullet2_done, bullet1_done};
  assign hit = {shot_hit2, shot_hit1};

  // next-state for key edges, win flags, headings and both player FSMs
  always_comb begin
    key_d = key_now;
    kedge = key_now & ~key_q;
    restart = kedge[2] & (|go_q);
    for (int i = 0; i < 2; i++) go_d[i] = !restart && (go_q[i] || hits_q[i] >= 4'(WIN_HITS));
    frz = |go_d;
    for (int i = 0; i < 2; i++) begin
      head_d[i] = (xm[i] == 10'h3FF && ym[i] == 10'd0) ? 2'b00 :
                  (xm[i] == 10'd1   && ym[i] == 10'd0) ? 2'b01 :
                  (xm[i] == 10'd0   && ym[i] == 10'd1) ? 2'b10 :
                  (xm[i] == 10'd0   && ym[i] == 10'h3FF) ? 2'b11 : head_q[i];
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      dir_d[i] = dir_q[i];
      hits_d[i] = hits_q[i];
      case (st_q[i])
        IDLE: if (kedge[i]) begin
          st_d[i] = LAUNCH;
          dir_d[i] = head_q[i];
        end
        LAUNCH: begin
          st_d[i] = FLIGHT;
          cnt_d[i] = '0;
        end
        FLIGHT: begin
          cnt_d[i] = cnt_q[i] + 8'd1;
          if (hit[i] || done[i] || cnt_q[i] == 8'(MAX_FLIGHT - 1)) begin
            st_d[i] = COOLDOWN;
            cnt_d[i] = '0;
          end
          if (hit[i]) hits_d[i] = (hits_q[i] == 4'hF) ? hits_q[i] : hits_q[i] + 4'd1;
        end
        default: begin
          st_d[i] = (cnt_q[i] == 8'(COOLDOWN_FRAMES - 1)) ? IDLE : COOLDOWN;
          cnt_d[i] = (cnt_q[i] == 8'(COOLDOWN_FRAMES - 1)) ? 8'd0 : cnt_q[i] + 8'd1;
        end
      endcase
      if (frz || restart) begin
        st_d[i] = IDLE;
        cnt_d[i] = '0;
        hits_d[i] = restart ? 4'd0 : hits_q[i];
      end
      if (restart) dir_d[i] = (i == 0) ? 2'b01 : 2'b00;
      fire_d[i] = st_d[i] == LAUNCH;
      busy_d[i] = st_d[i] != IDLE;
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= IDLE;
        cnt_q[i] <= '0;
        head_q[i] <= (i == 0) ? 2'b01 : 2'b00;
        dir_q[i] <= (i == 0) ? 2'b01 : 2'b00;
        hits_q[i] <= '0;
      end
      key_q <= '0;
      fire_q <= '0;
      busy_q <= '0;
      go_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        head_q[i] <= head_d[i];
        dir_q[i] <= dir_d[i];
        hits_q[i] <= hits_d[i];
      end
      key_q <= key_d;
      fire_q <= fire_d;
      busy_q <= busy_d;
      go_q <= go_d;
    end
  end

  assign fire1 = fire_q[0];
  assign fire2 = fire_q[1];
  assign fire_dir1 = dir_q[0];
  assign fire_dir2 = dir_q[1];
  assign busy1 = busy_q[0];
  assign busy2 = busy_q[1];
  assign hits1 = hits_q[0];
  assign hits2 = hits_q[1];
  assign game_over_display = go_q[0];
  assign game_over_display2 = go_q[1];
endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: directed self-checking bench for shot_sequencer
module tb_shot_sequencer;
  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [31:0] keycode;
  logic [9:0]  tank1_xmotion, tank1_ymotion, tank2_xmotion, tank2_ymotion;
  logic        bullet1_done, bullet2_done, shot_hit1, shot_hit2;
  logic        fire1, fire2, busy1, busy2, game_over_display, game_over_display2;
  logic [1:0]  fire_dir1, fire_dir2;
  logic [3:0]  hits1, hits2;
  int          n_chk = 0;
  int          n_fail = 0;

  shot_sequencer dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .tank1_xmotion(tank1_xmotion), .tank1_ymotion(tank1_ymotion),
    .tank2_xmotion(tank2_xmotion), .tank2_ymotion(tank2_ymotion),
    .bullet1_done(bullet1_done), .bullet2_done(bullet2_done),
    .shot_hit1(shot_hit1), .shot_hit2(shot_hit2),
    .fire1(fire1), .fire2(fire2), .fire_dir1(fire_dir1), .fire_dir2(fire_dir2),
    .busy1(busy1), .busy2(busy2), .hits1(hits1), .hits2(hits2),
    .game_over_display(game_over_display), .game_over_display2(game_over_display2)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic round(input logic p1, input logic p2);
    keycode = (p1 ? 32'h2C : 32'h0) | (p2 ? 32'h2800 : 32'h0);
    tick();
    keycode = '0;
    tick();
    shot_hit1 = p1;
    shot_hit2 = p2;
    tick();
    shot_hit1 = 1'b0;
    shot_hit2 = 1'b0;
    repeat (15) tick();
  endtask

  initial begin
    Reset_n = 1'b0;
    keycode = '0;
    tank1_xmotion = '0;
    tank1_ymotion = '0;
    tank2_xmotion = '0;
    tank2_ymotion = '0;
    bullet1_done = 1'b0;
    bullet2_done = 1'b0;
    shot_hit1 = 1'b0;
    shot_hit2 = 1'b0;
    #12;
    chk("rst_fire1", fire1, 0);
    chk("rst_fire2", fire2, 0);
    chk("rst_dir1", fire_dir1, 1);
    chk("rst_dir2", fire_dir2, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_hits1", hits1, 0);
    chk("rst_hits2", hits2, 0);
    chk("rst_go1", game_over_display, 0);
    chk("rst_go2", game_over_display2, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tank1_ymotion = 10'h3FF;
    tick();
    keycode = 32'h2C;
    tick();
    chk("press_fire1", fire1, 1);
    chk("press_dir1_up", fire_dir1, 3);
    chk("press_busy1", busy1, 1);
    tick();
    chk("held1_fire1", fire1, 0);
    tick();
    chk("held2_fire1", fire1, 0);
    keycode = '0;
    tank1_ymotion = '0;
    tank1_xmotion = 10'd1;
    tick();
    tick();
    chk("flight_dir1_hold", fire_dir1, 3);
    bullet1_done = 1'b1;
    shot_hit1 = 1'b1;
    tick();
    chk("done_hit_hits1", hits1, 1);
    chk("cool_busy1_first", busy1, 1);
    bullet1_done = 1'b0;
    shot_hit1 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) keycode = 32'h2C;
      if (i == 5) keycode = '0;
      tick();
      chk("cool_busy1", busy1, 1);
      chk("cool_nofire1", fire1, 0);
    end
    tick();
    chk("cool_end_busy1", busy1, 0);
    keycode = 32'h2C;
    tick();
    chk("fresh_fire1", fire1, 1);
    chk("fresh_dir1_right", fire_dir1, 1);
    keycode = '0;
    tick();
    chk("fresh_fire1_off", fire1, 0);
    repeat (120) tick();
    bullet1_done = 1'b1;
    shot_hit1 = 1'b1;
    tick();
    chk("timeout_hit_ignored", hits1, 1);
    bullet1_done = 1'b0;
    shot_hit1 = 1'b0;
    repeat (13) tick();
    chk("timeout_cool_busy1", busy1, 1);
    tick();
    chk("timeout_idle_busy1", busy1, 0);
    keycode = 32'h1500;
    tick();
    chk("restart_play_hits1", hits1, 1);
    keycode = '0;
    tank2_ymotion = 10'd1;
    tick();
    keycode = 32'h28000000;
    tick();
    chk("p2_fire2", fire2, 1);
    chk("p2_dir2_down", fire_dir2, 2);
    chk("p2_fire1_quiet", fire1, 0);
    keycode = '0;
    tick();
    bullet2_done = 1'b1;
    tick();
    chk("p2_done_hits2", hits2, 0);
    bullet2_done = 1'b0;
    repeat (15) tick();
    chk("p2_idle_busy2", busy2, 0);
    tank1_xmotion = '0;
    tank1_ymotion = 10'h3FF;
    round(1'b1, 1'b1);
    round(1'b1, 1'b1);
    round(1'b1, 1'b1);
    round(1'b0, 1'b1);
    chk("pre_draw_hits1", hits1, 4);
    chk("pre_draw_hits2", hits2, 4);
    chk("pre_draw_go1", game_over_display, 0);
    keycode = 32'h282C;
    tick();
    chk("draw_fire1", fire1, 1);
    chk("draw_fire2", fire2, 1);
    keycode = '0;
    tick();
    shot_hit1 = 1'b1;
    shot_hit2 = 1'b1;
    tick();
    chk("draw_hits1", hits1, 5);
    chk("draw_hits2", hits2, 5);
    chk("draw_go1_late", game_over_display, 0);
    shot_hit1 = 1'b0;
    shot_hit2 = 1'b0;
    tick();
    chk("draw_go1", game_over_display, 1);
    chk("draw_go2", game_over_display2, 1);
    chk("draw_busy1", busy1, 0);
    chk("draw_busy2", busy2, 0);
    keycode = 32'h282C;
    tick();
    chk("over_nofire1", fire1, 0);
    chk("over_nofire2", fire2, 0);
    chk("over_busy1", busy1, 0);
    keycode = '0;
    tick();
    chk("over_hits1_frozen", hits1, 5);
    chk("over_dir1", fire_dir1, 3);
    keycode = 32'h00150000;
    tick();
    chk("restart_go1", game_over_display, 0);
    chk("restart_go2", game_over_display2, 0);
    chk("restart_hits1", hits1, 0);
    chk("restart_hits2", hits2, 0);
    chk("restart_dir1", fire_dir1, 1);
    chk("restart_dir2", fire_dir2, 0);
    keycode = '0;
    tick();
    round(1'b1, 1'b0);
    chk("post_restart_hits1", hits1, 1);
    keycode = 32'h2C;
    tick();
    keycode = '0;
    tick();
    chk("midflight_busy1", busy1, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_busy1", busy1, 0);
    chk("async_rst_hits1", hits1, 0);
    chk("async_rst_dir1", fire_dir1, 1);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    chk("after_rst_fire1_a", fire1, 0);
    chk("after_rst_busy1_a", busy1, 0);
    tick();
    chk("after_rst_fire1_b", fire1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
